// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: DMCtrl access-size codes,
// the arbiter FSM states, and the request record latched at grant time.
// Also holds the alignment rule used when the optional check is built in.
package dmem_arb_pkg;

  localparam int DMEM_XLEN = 32;

  localparam logic [2:0] CTRL_B  = 3'b000;
  localparam logic [2:0] CTRL_H  = 3'b001;
  localparam logic [2:0] CTRL_W  = 3'b010;
  localparam logic [2:0] CTRL_BU = 3'b100;
  localparam logic [2:0] CTRL_HU = 3'b101;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef struct packed {
    logic                 wr;
    logic [2:0]           ctrl;
    logic [DMEM_XLEN-1:0] addr;
    logic [DMEM_XLEN-1:0] wdata;
  } dmem_req_t;

  // Halfwords need addr[0] clear, words need addr[1:0] clear; bytes never fault.
  function automatic logic misaligned(input logic [2:0] ctrl, input logic [1:0] a);
    logic m;
    m = 1'b0;
    case (ctrl)
      CTRL_B, CTRL_BU: m = 1'b0;
      CTRL_H, CTRL_HU: m = a[0];
      CTRL_W:          m = |a;
      default:         m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Purpose: 2-way round-robin pick between the two data-memory requesters.
// Latency: grant is combinational from req in the same cycle; pointer updates on grant.
// Backpressure: no grant while en is low; losers simply keep requesting.
module dmem_rr_arb #(
  parameter int RST_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Index of the port granted most recently; the other port wins a tie.
  logic last;

  // Pick a winner: a lone requester always wins, a tie goes to the port not served last.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Remember who was served; reset points away from RST_PRIO so it wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last <= (RST_PRIO == 0);
    else if (|gnt)
      last <= gnt[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Purpose: share one DATA_MEMORY between core LSU (port 0) and debug/DMA (port 1).
// Latency: grant in IDLE, one ACCESS cycle, response pulse 2 cycles after grant.
// Backpressure: requesters hold p_req until p_gnt; one transaction per 2 cycles.
// Optional: DMEM_ARB_ALIGN_CHECK_EN enables misaligned-access detection (rsp_err).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RST_PRIO = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           p_req,
  input  logic [1:0]           p_wr,
  input  logic [1:0][2:0]      p_ctrl,
  input  logic [1:0][XLEN-1:0] p_addr,
  input  logic [1:0][XLEN-1:0] p_wdata,
  output logic [1:0]           p_gnt,
  output logic [1:0]           p_rsp_valid,
  output logic [XLEN-1:0]      rsp_rdata,
  output logic                 rsp_err,
  output logic [XLEN-1:0]      Address,
  output logic [XLEN-1:0]      DataWr,
  output logic                 DMWr,
  output logic [2:0]           DMCtrl,
  input  logic [XLEN-1:0]      DataRd
);

  state_t    state;
  state_t    nxt;
  dmem_req_t req_q;
  logic      port_q;
  logic      arb_en;
  logic      win;
  logic      mis;

  // Arbitration only happens in IDLE; gating with rst keeps p_gnt low during reset.
  assign arb_en = (state == IDLE) && !rst;

  dmem_rr_arb #(
    .RST_PRIO (RST_PRIO)
  ) u_rr (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req (p_req),
    .gnt (p_gnt)
  );

  assign win = p_gnt[1];

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign mis = misaligned(req_q.ctrl, req_q.addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  // The latched request drives the memory bus; between accesses it simply holds.
  assign Address = req_q.addr;
  assign DataWr  = req_q.wdata;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= nxt;
  end

  // Next state and memory strobes; a misaligned store is suppressed at DMWr.
  always_comb begin
    nxt    = state;
    DMWr   = 1'b0;
    DMCtrl = CTRL_W;
    case (state)
      IDLE: begin
        if (|p_gnt)
          nxt = ACCESS;
      end
      ACCESS: begin
        DMWr   = req_q.wr & ~mis;
        DMCtrl = req_q.ctrl;
        nxt    = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Capture the winner's request fields and port id on the grant edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q  <= '0;
      port_q <= 1'b0;
    end else if (|p_gnt) begin
      req_q.wr    <= p_wr[win];
      req_q.ctrl  <= p_ctrl[win];
      req_q.addr  <= p_addr[win];
      req_q.wdata <= p_wdata[win];
      port_q      <= win;
    end
  end

  // Close the access: capture load data (zero for stores/faults) and pulse the owner's valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_rsp_valid <= 2'b00;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else if (state == ACCESS) begin
      p_rsp_valid <= port_q ? 2'b10 : 2'b01;
      rsp_rdata   <= (!req_q.wr && !mis) ? DataRd : '0;
      rsp_err     <= mis;
    end else begin
      p_rsp_valid <= 2'b00;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      p_req, p_wr;
  logic [1:0][2:0] p_ctrl;
  logic [1:0][31:0] p_addr, p_wdata;
  logic [1:0]      p_gnt, p_rsp_valid;
  logic [31:0]     rsp_rdata, Address, DataWr, DataRd;
  logic            rsp_err, DMWr;
  logic [2:0]      DMCtrl;

  always #5 clk = ~clk;

  dmem_arbiter #(.XLEN(32), .RST_PRIO(0)) dut (
    .clk(clk), .rst(rst), .p_req(p_req), .p_wr(p_wr), .p_ctrl(p_ctrl),
    .p_addr(p_addr), .p_wdata(p_wdata), .p_gnt(p_gnt), .p_rsp_valid(p_rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .Address(Address), .DataWr(DataWr),
    .DMWr(DMWr), .DMCtrl(DMCtrl), .DataRd(DataRd)
  );

  // Byte-addressed little-endian memory with size/sign handling on read.
  logic [7:0] mem [0:63];
  logic [5:0] a0, a1, a2, a3;
  assign a0 = Address[5:0];
  assign a1 = a0 + 6'd1;
  assign a2 = a0 + 6'd2;
  assign a3 = a0 + 6'd3;

  always @(posedge clk) begin
    if (DMWr) begin
      mem[a0] <= DataWr[7:0];
      if (DMCtrl[1:0] != 2'b00) mem[a1] <= DataWr[15:8];
      if (DMCtrl[1:0] == 2'b10) begin
        mem[a2] <= DataWr[23:16];
        mem[a3] <= DataWr[31:24];
      end
    end
  end

  always_comb begin
    DataRd = {mem[a3], mem[a2], mem[a1], mem[a0]};
    case (DMCtrl)
      3'b000:  DataRd = {{24{mem[a0][7]}}, mem[a0]};
      3'b001:  DataRd = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
      3'b100:  DataRd = {24'd0, mem[a0]};
      3'b101:  DataRd = {16'd0, mem[a1], mem[a0]};
      default: DataRd = {mem[a3], mem[a2], mem[a1], mem[a0]};
    endcase
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          gcyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   gnt_log[$];
  exp_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Monitor: grant legality and scoreboard pop on every response pulse.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (p_gnt != 2'b00) begin
        chk("gnt_onehot", 32'($onehot(p_gnt)), 32'd1);
        gnt_log.push_back(p_gnt[1] ? 1 : 0);
      end
      if (p_rsp_valid != 2'b00)
        chk("rsp_onehot", 32'($onehot(p_rsp_valid)), 32'd1);
      if (p_rsp_valid[0]) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp0_unexpected: got rdata %h required no response", rsp_rdata);
        end else begin
          mon_e = q0.pop_front();
          chk("rsp0_rdata", rsp_rdata, mon_e.rdata);
          chk("rsp0_err", 32'(rsp_err), 32'(mon_e.err));
          chk("rsp0_latency", 32'(cyc - mon_e.gcyc), 32'd2);
        end
      end
      if (p_rsp_valid[1]) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp1_unexpected: got rdata %h required no response", rsp_rdata);
        end else begin
          mon_e = q1.pop_front();
          chk("rsp1_rdata", rsp_rdata, mon_e.rdata);
          chk("rsp1_err", 32'(rsp_err), 32'(mon_e.err));
          chk("rsp1_latency", 32'(cyc - mon_e.gcyc), 32'd2);
        end
      end
    end
  end

  // Request on port p, wait for grant, push the expected response; optionally check the bus.
  task automatic issue(input logic p, input logic wr, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input logic exp_wr, input bit chk_bus);
    int   n;
    exp_t e;
    @(negedge clk);
    p_req[p] = 1'b1; p_wr[p] = wr; p_ctrl[p] = ctrl; p_addr[p] = addr; p_wdata[p] = wdata;
    #1;
    n = 0;
    while (!p_gnt[p] && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!p_gnt[p]) begin
      total++; bad++;
      $display("FAIL gnt_timeout: port %0d got no grant, required grant within 50 cycles", p);
      p_req[p] = 1'b0;
      return;
    end
    e.rdata = exp_rd; e.err = exp_err; e.gcyc = cyc;
    if (p) q1.push_back(e); else q0.push_back(e);
    @(negedge clk);
    p_req[p] = 1'b0;
    #1;
    if (chk_bus) begin
      chk("acc_addr", Address, addr);
      chk("acc_wdata", DataWr, wdata);
      chk("acc_ctrl", 32'(DMCtrl), 32'(ctrl));
      chk("acc_dmwr", 32'(DMWr), 32'(exp_wr));
      @(negedge clk); #1;
      chk("idle_dmwr", 32'(DMWr), 32'd0);
      chk("idle_ctrl", 32'(DMCtrl), 32'(CTRL_W));
      chk("idle_addr_hold", Address, addr);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    p_req = 2'b10; p_wr = '0; p_ctrl = '0; p_addr = '0; p_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt", 32'(p_gnt), 32'd0);
    chk("rst_rsp_valid", 32'(p_rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_addr", Address, 32'd0);
    chk("rst_datawr", DataWr, 32'd0);
    chk("rst_dmwr", 32'(DMWr), 32'd0);
    chk("rst_dmctrl", 32'(DMCtrl), 32'(CTRL_W));
    p_req = 2'b00;
    @(negedge clk);
    rst = 1'b0;

    // Store/load word round trip, then byte and halfword with sign handling.
    issue(1'b0, 1'b1, CTRL_W,  32'h0, 32'hAABBCCDD, 32'h0,        1'b0, 1'b1, 1'b1);
    issue(1'b0, 1'b0, CTRL_W,  32'h0, 32'h0,        32'hAABBCCDD, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 1'b1, CTRL_B,  32'h1, 32'hEE,       32'h0,        1'b0, 1'b1, 1'b1);
    issue(1'b1, 1'b0, CTRL_BU, 32'h1, 32'h0,        32'h000000EE, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 1'b0, CTRL_B,  32'h1, 32'h0,        32'hFFFFFFEE, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 1'b1, CTRL_W,  32'h4, 32'h0BADF00D, 32'h0,        1'b0, 1'b1, 1'b0);
    issue(1'b0, 1'b1, CTRL_H,  32'h2, 32'hFF55,     32'h0,        1'b0, 1'b1, 1'b1);
    issue(1'b0, 1'b0, CTRL_H,  32'h3, 32'h0, ALN ? 32'h0 : 32'h00000DFF, ALN, 1'b0, 1'b1);
    issue(1'b0, 1'b0, CTRL_HU, 32'h2, 32'h0,        32'h0000FF55, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 1'b0, CTRL_H,  32'h2, 32'h0,        32'hFFFFFF55, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 1'b0, CTRL_W,  32'h0, 32'h0,        32'hFF55EEDD, 1'b0, 1'b0, 1'b0);
    // Misaligned word store: suppressed when checking is built in.
    issue(1'b1, 1'b1, CTRL_W,  32'h8, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0);
    issue(1'b1, 1'b1, CTRL_W,  32'h9, 32'hDEADBEEF, 32'h0,        ALN,  !ALN, 1'b1);
    issue(1'b1, 1'b0, CTRL_W,  32'h8, 32'h0, ALN ? 32'h0 : 32'hADBEEF00, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a store's ACCESS cycle aborts it with no response.
    @(negedge clk);
    p_req[0] = 1'b1; p_wr[0] = 1'b1; p_ctrl[0] = CTRL_W; p_addr[0] = 32'h4; p_wdata[0] = 32'h12345678;
    #1;
    n = 0;
    while (!p_gnt[0] && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("abort_gnt", 32'(p_gnt[0]), 32'd1);
    @(negedge clk); #1;
    chk("abort_dmwr_pre", 32'(DMWr), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_dmwr_low", 32'(DMWr), 32'd0);
    p_req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Contention straight after reset: order 0,1,0,1; also reads back the aborted word.
    gnt_log.delete();
    fork
      begin
        issue(1'b0, 1'b0, CTRL_W,  32'h0, 32'h0, 32'hFF55EEDD, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 1'b0, CTRL_BU, 32'h1, 32'h0, 32'h000000EE, 1'b0, 1'b0, 1'b0);
      end
      begin
        issue(1'b1, 1'b0, CTRL_HU, 32'h2, 32'h0, 32'h0000FF55, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 1'b0, CTRL_W,  32'h4, 32'h0, 32'h0BADF00D, 1'b0, 1'b0, 1'b0);
      end
    join
    chk("rr_count", 32'(gnt_log.size()), 32'd4);
    if (gnt_log.size() == 4) begin
      chk("rr_order0", 32'(gnt_log[0]), 32'd0);
      chk("rr_order1", 32'(gnt_log[1]), 32'd1);
      chk("rr_order2", 32'(gnt_log[2]), 32'd0);
      chk("rr_order3", 32'(gnt_log[3]), 32'd1);
    end

    repeat (5) @(negedge clk);
    #3;
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter XLEN, default 32, address and data width; only 32 is supported.
REQ-002 Parameter RST_PRIO, default 0, index of the port that wins the first contested arbitration after reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 p_req  input  2  per-port request; bit i belongs to port i (0 = core LSU, 1 = debug/DMA).
REQ-006 p_wr  input  2  per-port write flag (1 = store, 0 = load).
REQ-007 p_ctrl  input  2x3  per-port DMCtrl code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 p_addr  input  2xXLEN  per-port byte address.
REQ-009 p_wdata  input  2xXLEN  per-port store data, right-aligned.
REQ-010 p_gnt  output  2  one-hot request-accepted pulse.
REQ-011 p_rsp_valid  output  2  one-hot response pulse, issued for loads and stores.
REQ-012 rsp_rdata  output  XLEN  load data, valid while any p_rsp_valid bit is high.
REQ-013 rsp_err  output  1  misalignment error flag, valid with p_rsp_valid.
REQ-014 Address, DataWr, DMWr, DMCtrl  output  XLEN/XLEN/1/3  memory-side drive to DATA_MEMORY.
REQ-015 DataRd  input  XLEN  memory combinational read data.

Function
REQ-016 FSM states are IDLE and ACCESS; reset enters IDLE.
REQ-017 IDLE with any p_req: p_gnt of the winner is asserted combinationally in that cycle, the winner's wr/ctrl/addr/wdata and the port id are latched, and the FSM moves to ACCESS.
REQ-018 Contention: when both ports request, the port not granted last wins (2-way round robin). A single requester always wins.
REQ-019 ACCESS lasts exactly one cycle and drives Address/DataWr/DMCtrl from the latched fields, with DMWr = latched wr; the memory commits the store at the closing edge.
REQ-020 At the ACCESS closing edge: for a load, DataRd is captured into rsp_rdata; for a store, rsp_rdata is set to 0. The FSM then returns to IDLE.
REQ-021 p_rsp_valid of the latched port pulses for exactly one cycle, the cycle after ACCESS; a new grant may occur in that same cycle.
REQ-022 Throughput is one transaction per 2 cycles; load latency from grant to response is 2 cycles.
REQ-023 Outside ACCESS, DMWr = 0, DMCtrl = 010, and Address/DataWr hold their last value.
REQ-024 A requester holds p_req and its fields stable until p_gnt; p_req deasserted before grant is a withdrawal, with no side effect.
REQ-025 A request arriving during ACCESS waits; it is not granted before the next IDLE cycle.

Reset
REQ-026 Reset value of every output is 0, except DMCtrl = 010.
REQ-027 Reset values: FSM = IDLE, latched fields = 0, last-grant pointer = ~RST_PRIO.
REQ-028 Reset asserted during ACCESS forces DMWr low immediately; the store is not committed and no p_rsp_valid is issued.

Configuration
REQ-029 DMEM_ARB_ALIGN_CHECK_EN defined: a halfword with addr[0] = 1, or a word with addr[1:0] != 00, is misaligned.
REQ-030 A misaligned access still takes ACCESS, but holds DMWr = 0 and returns rsp_rdata = 0 with rsp_err = 1.
REQ-031 DMEM_ARB_ALIGN_CHECK_EN undefined: rsp_err is tied to 0 and every access is forwarded unchanged.

Structure
REQ-032 Package dmem_arb_pkg holds the DMCtrl code constants, the state enum {IDLE, ACCESS}, and a packed request struct {wr, ctrl, addr, wdata}.
REQ-033 Sub-module dmem_rr_arb: combinational 2-way round-robin pick from req[1:0] and the last-grant pointer; this module owns the pointer register.

Verification
REQ-034 Port 0 stores W 0xAABBCCDD @0x0, then loads W @0x0: rsp_rdata = 0xAABBCCDD, p_rsp_valid = 01, 2 cycles after the load grant.
REQ-035 Both ports request in the same cycle after reset (RST_PRIO = 0): grant order 0,1,0,1; p_gnt is never 11.
REQ-036 Port 1 stores B 0xEE @0x1, then loads BU @0x1 and B @0x1: rsp_rdata = 0x000000EE, then 0xFFFFFFEE.
REQ-037 Port 0 stores H 0xFF55 @0x2 with ALIGN_CHECK_EN: DMWr = 1 for one cycle; a load H @0x3 gives rsp_err = 1, DMWr = 0, rsp_rdata = 0.
REQ-038 Pulse rst mid-ACCESS of a store W 0x12345678 @0x4: a later load W @0x4 returns the previous contents, and no response pulse is issued.
